// File: rtl/vita49_pkg.sv
// Shared VITA-49 header field positions, packet type constant and write FSM encoding
// used by the receive-path packet filter.
package vita49_pkg;

    localparam int unsigned HDR_TYPE_MSB    = 31;
    localparam int unsigned HDR_TYPE_LSB    = 28;
    localparam int unsigned HDR_PKT_CNT_MSB = 19;
    localparam int unsigned HDR_PKT_CNT_LSB = 16;
    localparam int unsigned HDR_SIZE_MSB    = 15;
    localparam int unsigned HDR_SIZE_LSB    = 0;

    localparam logic [3:0] VITA49_TYPE_SIG_SID = 4'h1;

    typedef enum logic [1:0] {
        ST_HDR,
        ST_SID,
        ST_BODY,
        ST_DISCARD
    } wr_state_t;

    function automatic logic [3:0] hdr_type(input logic [31:0] word);
        return word[HDR_TYPE_MSB:HDR_TYPE_LSB];
    endfunction

    function automatic logic [3:0] hdr_pkt_cnt(input logic [31:0] word);
        return word[HDR_PKT_CNT_MSB:HDR_PKT_CNT_LSB];
    endfunction

    function automatic logic [15:0] hdr_size(input logic [31:0] word);
        return word[HDR_SIZE_MSB:HDR_SIZE_LSB];
    endfunction

endpackage

// File: rtl/vita49_pkt_filter_ram.sv
// Simple dual-port packet buffer: one write port, one read port with a registered,
// enable-gated output so the read data holds while the consumer stalls.
module vita49_pkt_filter_ram #(
    parameter int DEPTH_LOG2 = 9,
    parameter int DATA_W     = 33
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/vita49_pkt_filter.sv
// Store-and-forward VITA-49 packet filter: buffers, validates at TLAST, commits or rewinds.
// Optional packet-count continuity tracking is built when VITA49_FILTER_SEQ_CHECK_EN is defined.
module vita49_pkt_filter
    import vita49_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic        AXIS_ACLK,
    input  logic        AXIS_ARESETN,
    input  logic [31:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TVALID,
    input  logic        S_AXIS_TLAST,
    output logic        S_AXIS_TREADY,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TVALID,
    output logic        M_AXIS_TLAST,
    input  logic        M_AXIS_TREADY,
    input  logic        enable,
    input  logic [31:0] stream_id,
    input  logic        sid_check,
    output logic [15:0] drop_cnt,
    output logic [15:0] seq_err_cnt,
    output logic        drop_stb
);

    localparam int unsigned DEPTH = 2**DEPTH_LOG2;
    localparam int          PW    = DEPTH_LOG2 + 1;

    wr_state_t     state;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] commit_ptr;
    logic [PW-1:0] rd_ptr;
    logic [15:0]   wcnt;
    logic [3:0]    pkt_type;
    logic [15:0]   pkt_size;
    logic          sid_ok;
    logic          en_at_hdr;
    logic          rdy_en;
    logic          m_valid;
    logic [32:0]   rd_word;

    logic          full;
    logic          s_hs;
    logic          wr_en;
    logic [15:0]   wcnt_nxt;
    logic          pkt_good;
    logic          commit;
    logic          drop;
    logic          ovf;
    logic          rd_en;

    // Full compares against rd_ptr, so output draining frees space for the packet in flight.
    assign full = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                  (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);

    assign S_AXIS_TREADY = rdy_en && ((state == ST_DISCARD) || !full);
    assign s_hs          = S_AXIS_TVALID && S_AXIS_TREADY;
    assign wr_en         = s_hs && (state != ST_DISCARD);
    assign wcnt_nxt      = wcnt + 16'd1;

    assign pkt_good = (pkt_type == VITA49_TYPE_SIG_SID) &&
                      (pkt_size == wcnt_nxt) &&
                      (sid_ok || !sid_check) &&
                      en_at_hdr;

    assign commit = s_hs && S_AXIS_TLAST && (state == ST_BODY) && pkt_good;
    assign drop   = s_hs && S_AXIS_TLAST && !commit;
    assign ovf    = s_hs && !S_AXIS_TLAST && (state != ST_DISCARD) &&
                    (wcnt_nxt == 16'(DEPTH));

    assign rd_en = (rd_ptr != commit_ptr) && (!m_valid || M_AXIS_TREADY);

    vita49_pkt_filter_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (33)
    ) u_ram (
        .clk   (AXIS_ACLK),
        .we    (wr_en),
        .waddr (wr_ptr[PW-2:0]),
        .wdata ({S_AXIS_TLAST, S_AXIS_TDATA}),
        .re    (rd_en),
        .raddr (rd_ptr[PW-2:0]),
        .rdata (rd_word)
    );

    assign M_AXIS_TVALID = m_valid;
    assign M_AXIS_TDATA  = m_valid ? rd_word[31:0] : '0;
    assign M_AXIS_TLAST  = m_valid && rd_word[32];

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state      <= ST_HDR;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            wcnt       <= '0;
            pkt_type   <= '0;
            pkt_size   <= '0;
            sid_ok     <= 1'b0;
            en_at_hdr  <= 1'b0;
            rdy_en     <= 1'b0;
            m_valid    <= 1'b0;
            drop_cnt   <= '0;
            drop_stb   <= 1'b0;
        end else begin
            rdy_en   <= 1'b1;
            drop_stb <= 1'b0;

            if (rd_en) begin
                rd_ptr  <= rd_ptr + PW'(1);
                m_valid <= 1'b1;
            end else if (M_AXIS_TREADY) begin
                m_valid <= 1'b0;
            end

            if (s_hs) begin
                wcnt <= S_AXIS_TLAST ? '0 : wcnt_nxt;

                unique case (state)
                    ST_HDR: begin
                        pkt_type  <= hdr_type(S_AXIS_TDATA);
                        pkt_size  <= hdr_size(S_AXIS_TDATA);
                        en_at_hdr <= enable;
                        state     <= S_AXIS_TLAST ? ST_HDR : ST_SID;
                    end
                    ST_SID: begin
                        sid_ok <= (S_AXIS_TDATA == stream_id);
                        state  <= S_AXIS_TLAST ? ST_HDR : ST_BODY;
                    end
                    ST_BODY: begin
                        if (S_AXIS_TLAST) state <= ST_HDR;
                    end
                    ST_DISCARD: begin
                        if (S_AXIS_TLAST) state <= ST_HDR;
                    end
                    default: state <= ST_HDR;
                endcase

                if (wr_en) wr_ptr <= wr_ptr + PW'(1);
                if (commit) commit_ptr <= wr_ptr + PW'(1);

                // Rewind wins over the increment; commit_ptr is the floor so committed data is safe.
                if (drop || ovf) wr_ptr <= commit_ptr;
                if (ovf) state <= ST_DISCARD;

                if (drop) begin
                    drop_stb <= 1'b1;
                    if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end

`ifdef VITA49_FILTER_SEQ_CHECK_EN
    logic [3:0]  cur_pkt_cnt;
    logic [3:0]  last_pkt_cnt;
    logic        seq_vld;
    logic        enable_q;
    logic [15:0] seq_err_q;
    logic        en_rise;

    assign en_rise = enable && !enable_q;

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            cur_pkt_cnt  <= '0;
            last_pkt_cnt <= '0;
            seq_vld      <= 1'b0;
            enable_q     <= 1'b0;
            seq_err_q    <= '0;
        end else begin
            enable_q <= enable;
            if (s_hs && (state == ST_HDR)) begin
                cur_pkt_cnt <= hdr_pkt_cnt(S_AXIS_TDATA);
            end
            if (commit) begin
                last_pkt_cnt <= cur_pkt_cnt;
                seq_vld      <= 1'b1;
                if (seq_vld && !en_rise && (cur_pkt_cnt != (last_pkt_cnt + 4'd1)) &&
                    (seq_err_q != '1)) begin
                    seq_err_q <= seq_err_q + 16'd1;
                end
            end else if (en_rise) begin
                seq_vld <= 1'b0;
            end
        end
    end

    assign seq_err_cnt = seq_err_q;
`else
    assign seq_err_cnt = '0;
`endif

endmodule
